// File: rtl/vga_pixel_unpack.sv
// vga_pixel_unpack
// Pops DATA_WIDTH-bit words from the (non-show-ahead) pixel data FIFO and
// keeps up to two of them buffered. Each word is split into PIXEL_WIDTH-bit
// pixels, lane 0 (LSBs) first, and one pixel is served per pix_req. When no
// word is ready the fixed UNDERFLOW_COLOR is shown and the event is counted
// per frame.
//
// Ports:
//   clk               single clock
//   reset             asynchronous, active-high reset
//   data_fifo_empty   FIFO empty flag
//   data_fifo_rd_data FIFO read data, valid one cycle after a pop
//   vga_rd_valid      FIFO pop strobe
//   pix_req           one pixel requested this cycle
//   frame_start       one-cycle pulse at frame start
//   pix_data          output pixel (one cycle after pix_req)
//   pix_valid         pix_data valid
//   underflow         sticky underflow flag since last frame_start
//   underflow_count   underflow pixels since last frame_start (saturating)
module vga_pixel_unpack #(
  parameter int unsigned                 DATA_WIDTH      = 128,
  parameter int unsigned                 PIXEL_WIDTH     = 32,
  parameter int unsigned                 PIXELS_PER_WORD = DATA_WIDTH / PIXEL_WIDTH,
  parameter logic [PIXEL_WIDTH-1:0]      UNDERFLOW_COLOR = 32'h00FF00FF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data_fifo_empty,
  input  logic [DATA_WIDTH-1:0]  data_fifo_rd_data,
  output logic                   vga_rd_valid,
  input  logic                   pix_req,
  input  logic                   frame_start,
  output logic [PIXEL_WIDTH-1:0] pix_data,
  output logic                   pix_valid,
  output logic                   underflow,
  output logic [15:0]            underflow_count
);

  localparam int unsigned LANE_W = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIXELS_PER_WORD - 1);

  logic [DATA_WIDTH-1:0]  cur, nxt;
  logic                   cur_v, nxt_v;
  logic                   inflight;
  logic [LANE_W-1:0]      lane;

  logic                   serve, consume, uf_event;
  logic                   cur_v_a, nxt_v_a;
  logic [1:0]             occupancy;
  logic [PIXEL_WIDTH-1:0] lane_pix;

  // Slot state as it will be after this cycle's consumption; both the pop
  // decision and the landing slot are based on it, so a word consumed this
  // cycle frees its slot immediately.
  always_comb begin
    serve     = pix_req && cur_v;
    consume   = serve && (lane == LAST_LANE);
    uf_event  = pix_req && !cur_v;
    cur_v_a   = cur_v;
    nxt_v_a   = nxt_v;
    if (consume) begin
      cur_v_a = nxt_v;
      nxt_v_a = 1'b0;
    end
    occupancy    = {1'b0, cur_v_a} + {1'b0, nxt_v_a} + {1'b0, inflight};
    vga_rd_valid = !reset && !data_fifo_empty && (occupancy < 2'd2);
    lane_pix     = cur[lane*PIXEL_WIDTH +: PIXEL_WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur             <= '0;
      nxt             <= '0;
      cur_v           <= 1'b0;
      nxt_v           <= 1'b0;
      inflight        <= 1'b0;
      lane            <= '0;
      pix_data        <= '0;
      pix_valid       <= 1'b0;
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else begin
      inflight <= vga_rd_valid;

      // Shift first, then let a landing word override the freed slot.
      if (consume) begin
        cur <= nxt;
      end
      cur_v <= cur_v_a;
      nxt_v <= nxt_v_a;
      if (inflight) begin
        if (!cur_v_a) begin
          cur   <= data_fifo_rd_data;
          cur_v <= 1'b1;
        end else begin
          nxt   <= data_fifo_rd_data;
          nxt_v <= 1'b1;
        end
      end

      if (serve) begin
        lane <= consume ? '0 : lane + 1'b1;
      end

      pix_valid <= pix_req;
      if (serve) begin
        pix_data <= lane_pix;
      end else if (pix_req) begin
        pix_data <= UNDERFLOW_COLOR;
      end

      // A same-cycle underflow survives the frame_start clear as count 1.
      if (frame_start) begin
        underflow       <= uf_event;
        underflow_count <= uf_event ? 16'd1 : '0;
      end else if (uf_event) begin
        underflow <= 1'b1;
        if (underflow_count != '1) begin
          underflow_count <= underflow_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_unpack.sv
module tb_vga_pixel_unpack;

  localparam logic [31:0] UC = 32'h00FF00FF;

  logic         clk = 1'b0;
  logic         reset;
  logic         data_fifo_empty;
  logic [127:0] data_fifo_rd_data = '0;
  logic         vga_rd_valid;
  logic         pix_req;
  logic         frame_start;
  logic [31:0]  pix_data;
  logic         pix_valid;
  logic         underflow;
  logic [15:0]  underflow_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_pixel_unpack #(
    .DATA_WIDTH(128),
    .PIXEL_WIDTH(32),
    .UNDERFLOW_COLOR(32'h00FF00FF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_fifo_empty(data_fifo_empty),
    .data_fifo_rd_data(data_fifo_rd_data),
    .vga_rd_valid(vga_rd_valid),
    .pix_req(pix_req),
    .frame_start(frame_start),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .underflow(underflow),
    .underflow_count(underflow_count)
  );

  // Non-show-ahead FIFO model: writer owns wr_ptr, pop process owns rd_ptr.
  logic [127:0] fifo_mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign data_fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (vga_rd_valid && !data_fifo_empty) begin
      data_fifo_rd_data <= fifo_mem[rd_ptr];
      rd_ptr            <= rd_ptr + 1;
    end
  end

  // Scoreboard: requests push expected pixels, monitor pops on pix_valid.
  logic [31:0] exp_q [$];
  logic        req_d;

  always @(posedge clk or posedge reset) begin
    if (reset) req_d <= 1'b0;
    else       req_d <= pix_req;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    checks++;
    if (pix_valid !== req_d) begin
      errors++;
      $display("FAIL pix_valid: got %b expected %b at %0t", pix_valid, req_d, $time);
    end
    if (pix_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel: got %h expected none at %0t", pix_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (pix_data !== e) begin
          errors++;
          $display("FAIL pix_data: got %h expected %h at %0t", pix_data, e, $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_val(input int k, input int i);
    return 32'hA000_0000 | (32'(k) << 8) | 32'(i);
  endfunction

  function automatic logic [127:0] mkword(input int k);
    logic [127:0] w;
    for (int i = 0; i < 4; i++) w[i*32 +: 32] = lane_val(k, i);
    return w;
  endfunction

  task automatic push_word(input logic [127:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic issue_req(input logic [31:0] exp);
    pix_req = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    pix_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int mark;
    reset       = 1'b1;
    pix_req     = 1'b0;
    frame_start = 1'b0;
    push_word(128'h44444444_33333333_22222222_11111111);
    repeat (2) @(negedge clk);
    check("rst_pix_data", pix_data, 32'h0);
    check("rst_pix_valid", {31'b0, pix_valid}, 32'h0);
    check("rst_underflow", {31'b0, underflow}, 32'h0);
    check("rst_count", {16'b0, underflow_count}, 32'h0);
    check("rst_rd_valid", {31'b0, vga_rd_valid}, 32'h0);
    reset = 1'b0;
    idle(3);

    // Single word, lane 0 first
    issue_req(32'h11111111);
    issue_req(32'h22222222);
    issue_req(32'h33333333);
    issue_req(32'h44444444);
    idle(1);
    check("single_underflow", {31'b0, underflow}, 32'h0);

    // Prefetch bound
    mark = rd_ptr;
    for (int k = 0; k < 5; k++) push_word(mkword(k));
    idle(8);
    check("prefetch_pops", 32'(rd_ptr - mark), 32'd2);
    check("prefetch_rd_valid", {31'b0, vga_rd_valid}, 32'h0);
    for (int i = 0; i < 4; i++) issue_req(lane_val(0, i));
    idle(4);
    check("prefetch_pops_after", 32'(rd_ptr - mark), 32'd3);

    // Continuous stream: words 1..10 back to back
    for (int k = 5; k <= 10; k++) push_word(mkword(k));
    for (int k = 1; k <= 10; k++)
      for (int i = 0; i < 4; i++) issue_req(lane_val(k, i));
    idle(3);

    // Underflow with empty buffer
    repeat (3) issue_req(UC);
    idle(0);
    check("uf_flag", {31'b0, underflow}, 32'h1);
    check("uf_count3", {16'b0, underflow_count}, 32'd3);
    repeat (4) issue_req(UC);
    idle(0);
    check("uf_count7", {16'b0, underflow_count}, 32'd7);
    push_word(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    idle(3);
    issue_req(32'hAAAAAAAA);
    idle(1);

    // frame_start clears counters but keeps word and lane
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("fs_underflow", {31'b0, underflow}, 32'h0);
    check("fs_count", {16'b0, underflow_count}, 32'h0);
    issue_req(32'hBBBBBBBB);
    issue_req(32'hCCCCCCCC);
    issue_req(32'hDDDDDDDD);
    idle(1);
    check("fs_count_hold", {16'b0, underflow_count}, 32'h0);
    repeat (2) issue_req(UC);
    idle(0);
    check("uf_count2", {16'b0, underflow_count}, 32'd2);
    frame_start = 1'b1;
    issue_req(UC);
    frame_start = 1'b0;
    idle(0);
    check("fs_uf_flag", {31'b0, underflow}, 32'h1);
    check("fs_uf_count", {16'b0, underflow_count}, 32'd1);

    // Async reset mid-word (lane 2), FIFO non-empty during reset
    push_word(mkword(20));
    push_word(mkword(21));
    idle(3);
    push_word(mkword(22));
    issue_req(lane_val(20, 0));
    issue_req(lane_val(20, 1));
    pix_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_pix_data", pix_data, 32'h0);
    check("arst_pix_valid", {31'b0, pix_valid}, 32'h0);
    check("arst_underflow", {31'b0, underflow}, 32'h0);
    check("arst_count", {16'b0, underflow_count}, 32'h0);
    check("arst_rd_valid", {31'b0, vga_rd_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    issue_req(lane_val(22, 0));
    idle(3);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
